// File: rtl/alu_sequencer.sv
// alu_sequencer: a small program store of {A, B, OP, last} entries that is
// replayed to a downstream ALU one entry per accepted transfer.
// Handshake: an entry moves when valid and ready are both high at a rising
// edge. While valid is high and ready is low, A/B/OP/step hold steady.
// While valid is low, A/B/OP are driven to zero.
module alu_sequencer #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8,
  parameter int OPW   = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [WIDTH-1:0] prog_a,
  input  logic [WIDTH-1:0] prog_b,
  input  logic [OPW-1:0]   prog_op,
  input  logic             prog_last,
  input  logic             start,
  input  logic             loop,
  input  logic             abort,
  input  logic             ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [OPW-1:0]   OP,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    step,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mem_a [DEPTH];
  logic [WIDTH-1:0] r_mem_b [DEPTH];
  logic [OPW-1:0]   r_mem_op [DEPTH];
  logic             r_mem_last [DEPTH];
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OPW-1:0]   r_op;
  logic             r_valid;
  logic             r_done;
  logic             r_loop;
  logic [AW-1:0]    r_step;

  logic             w_wr_idle;
  logic             w_wr0;
  logic [WIDTH-1:0] w_e0_a;
  logic [WIDTH-1:0] w_e0_b;
  logic [OPW-1:0]   w_e0_op;
  logic             w_is_last;
  logic [AW-1:0]    w_nxt_step;

  // Program writes are only accepted while no run is in progress.
  assign w_wr_idle = prog_we && (r_state == S_IDLE);
  assign w_wr0     = w_wr_idle && (prog_addr == '0);

  // Entry 0 as seen on the start edge, including a same-cycle write to it.
  assign w_e0_a  = w_wr0 ? prog_a  : r_mem_a[0];
  assign w_e0_b  = w_wr0 ? prog_b  : r_mem_b[0];
  assign w_e0_op = w_wr0 ? prog_op : r_mem_op[0];

  // The top entry always ends a pass so the pointer can never wrap silently.
  assign w_is_last  = r_mem_last[r_step] || (r_step == AW'(DEPTH - 1));
  assign w_nxt_step = w_is_last ? '0 : r_step + AW'(1);

  // Program store: cleared by reset, written only while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_a[i]    <= '0;
        r_mem_b[i]    <= '0;
        r_mem_op[i]   <= '0;
        r_mem_last[i] <= 1'b0;
      end
    end else if (w_wr_idle) begin
      r_mem_a[prog_addr]    <= prog_a;
      r_mem_b[prog_addr]    <= prog_b;
      r_mem_op[prog_addr]   <= prog_op;
      r_mem_last[prog_addr] <= prog_last;
    end
  end

  // Sequencer FSM with registered ALU-facing outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_loop  <= 1'b0;
      r_step  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_loop  <= loop;
            r_step  <= '0;
            r_valid <= 1'b1;
            r_a     <= w_e0_a;
            r_b     <= w_e0_b;
            r_op    <= w_e0_op;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_step  <= '0;
          end else if (ready) begin
            if (w_is_last && !r_loop) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_a     <= '0;
              r_b     <= '0;
              r_op    <= '0;
              r_step  <= '0;
            end else begin
              r_step <= w_nxt_step;
              r_a    <= r_mem_a[w_nxt_step];
              r_b    <= r_mem_b[w_nxt_step];
              r_op   <= r_mem_op[w_nxt_step];
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_a     <= '0;
          r_b     <= '0;
          r_op    <= '0;
          r_step  <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign OP        = r_op;
  assign valid     = r_valid;
  assign done      = r_done;
  assign step      = r_step;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and randomized program runs of alu_sequencer,
// each checked cycle by cycle against the visit order derived from the
// programmed contents and last flags.
module tb_alu_sequencer;
  localparam int WIDTH = 6;
  localparam int DEPTH = 8;
  localparam int OPW   = 2;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             prog_we;
  logic [AW-1:0]    prog_addr;
  logic [WIDTH-1:0] prog_a;
  logic [WIDTH-1:0] prog_b;
  logic [OPW-1:0]   prog_op;
  logic             prog_last;
  logic             start;
  logic             loop;
  logic             abort;
  logic             ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [OPW-1:0]   OP;
  logic             valid;
  logic             busy;
  logic             done;
  logic [AW-1:0]    step;
  logic [1:0]       dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  // Reference program image.
  logic [WIDTH-1:0] m_a [DEPTH];
  logic [WIDTH-1:0] m_b [DEPTH];
  logic [OPW-1:0]   m_op [DEPTH];
  logic             m_last [DEPTH];
  logic [AW-1:0]    exp_q [$];
  logic [1:0]       idle_state;

  // Clock / reset
  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OPW(OPW)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_a(prog_a), .prog_b(prog_b), .prog_op(prog_op), .prog_last(prog_last),
    .start(start), .loop(loop), .abort(abort), .ready(ready),
    .A(A), .B(B), .OP(OP), .valid(valid), .busy(busy), .done(done),
    .step(step), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_a[i] = '0; m_b[i] = '0; m_op[i] = '0; m_last[i] = 1'b0;
    end
  endtask

  function automatic bit ends_pass(input int idx);
    return m_last[idx] || (idx == DEPTH - 1);
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_A"}, A, 0);
    chk({tag, "_B"}, B, 0);
    chk({tag, "_OP"}, OP, 0);
  endtask

  // Driver: one program write while idle.
  task automatic prog_write(input int addr, input int a, input int b, input int op, input bit last);
    prog_we = 1'b1; prog_addr = AW'(addr); prog_a = WIDTH'(a);
    prog_b = WIDTH'(b); prog_op = OPW'(op); prog_last = last;
    tick();
    prog_we = 1'b0;
    m_a[addr] = WIDTH'(a); m_b[addr] = WIDTH'(b);
    m_op[addr] = OPW'(op); m_last[addr] = last;
  endtask

  // Driver + scoreboard for one run. In loop mode, n_xfer transfers are
  // checked and the run is then aborted.
  task automatic run_seq(input bit lp, input int n_xfer, input int rdy_pct,
                         input int stall_idx, input int stall_n,
                         input bit poke, input bit wr0);
    int idx;
    int stalls;
    int guard;
    bit rdy;
    bit first;
    stalls = stall_n;
    if (wr0) begin
      prog_we = 1'b1; prog_addr = '0; prog_a = WIDTH'($urandom);
      prog_b = WIDTH'($urandom); prog_op = OPW'($urandom); prog_last = 1'($urandom);
      m_a[0] = prog_a; m_b[0] = prog_b; m_op[0] = prog_op; m_last[0] = prog_last;
    end
    exp_q.delete();
    idx = 0;
    if (lp) begin
      for (int k = 0; k < n_xfer; k++) begin
        exp_q.push_back(AW'(idx));
        idx = ends_pass(idx) ? 0 : idx + 1;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        exp_q.push_back(AW'(idx));
        if (ends_pass(idx)) break;
        idx++;
      end
    end
    start = 1'b1; loop = lp;
    tick();
    start = 1'b0; loop = 1'($urandom); prog_we = 1'b0;
    guard = 0;
    first = 1'b1;
    while (exp_q.size() > 0 && guard < 200) begin
      guard++;
      if (first) chk("dbg_state_run", (dbg_state != idle_state), 1);
      first = 1'b0;
      chk("valid", valid, 1);
      chk("busy", busy, 1);
      chk("done", done, 0);
      chk("step", step, exp_q[0]);
      chk("A", A, m_a[exp_q[0]]);
      chk("B", B, m_b[exp_q[0]]);
      chk("OP", OP, m_op[exp_q[0]]);
      rdy = ($urandom_range(99) < rdy_pct);
      if (stalls > 0 && int'(exp_q[0]) == stall_idx) begin
        rdy = 1'b0;
        stalls--;
      end
      ready = rdy;
      start = 1'($urandom);
      if (poke) begin
        prog_we = 1'b1; prog_addr = AW'($urandom); prog_a = WIDTH'($urandom);
        prog_b = WIDTH'($urandom); prog_op = OPW'($urandom); prog_last = 1'($urandom);
      end
      tick();
      if (rdy) void'(exp_q.pop_front());
    end
    if (guard >= 200) chk("run_budget_expired", 1, 0);
    start = 1'b0; prog_we = 1'b0;
    if (lp) begin
      abort = 1'b1; ready = 1'($urandom);
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_step", step, 0);
      chk_quiet("abort");
      tick();
      chk("abort_done_after", done, 0);
    end else begin
      chk("end_done", done, 1);
      chk("end_busy", busy, 1);
      chk_quiet("end");
      ready = 1'($urandom);
      tick();
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_step", step, 0);
      chk_quiet("idle");
    end
    ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_a = '0; prog_b = '0;
    prog_op = '0; prog_last = 1'b0; start = 1'b0; loop = 1'b0; abort = 1'b0;
    ready = 1'b0;
    model_clear();
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step, 0);
    chk_quiet("rst");
    idle_state = dbg_state;
    tick(); tick();
    reset = 1'b1;
    tick();

    // Basic three-entry program, ready held high.
    prog_write(0, 42, 21, 0, 0);
    prog_write(1, 60, 3, 1, 0);
    prog_write(2, 0, 0, 0, 1);
    run_seq(0, 0, 100, -1, 0, 0, 0);
    // Backpressure: entry 1 stalled for three cycles.
    run_seq(0, 0, 100, 1, 3, 0, 0);
    // Looping: seven transfers then abort.
    run_seq(1, 7, 100, -1, 0, 0, 0);

    // Asynchronous reset while step is 1.
    start = 1'b1; loop = 1'b1;
    tick();
    start = 1'b0; ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("pre_reset_step", step, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_step", step, 0);
    chk("async_done", done, 0);
    chk_quiet("async");
    model_clear();
    tick();
    reset = 1'b1;
    tick();
    // Cleared program: eight zero entries, no last flags.
    run_seq(0, 0, 100, -1, 0, 0, 0);

    // No last flags: run ends after the top entry.
    for (int i = 0; i < DEPTH; i++)
      prog_write(i, $urandom, $urandom, $urandom, 0);
    run_seq(0, 0, 100, -1, 0, 0, 0);

    // Writes attempted during a run must not land.
    run_seq(0, 0, 60, -1, 0, 1, 0);
    run_seq(0, 0, 100, -1, 0, 0, 0);

    // Start together with a write to entry 0.
    run_seq(0, 0, 100, -1, 0, 0, 1);

    // Randomized programs and modes.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < DEPTH; i++)
        prog_write(i, $urandom, $urandom, $urandom, ($urandom_range(3) == 0));
      run_seq(1'($urandom), $urandom_range(20, 1), $urandom_range(100, 30),
              -1, 0, 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter WIDTH, default 6, operand width of A/B and program entries.
REQ-002 Parameter DEPTH, default 8, number of program entries (power of 2, >=2); AW = clog2(DEPTH).
REQ-003 Parameter OPW, default 2, opcode width.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 prog_we  input  1  program write strobe; honoured only in IDLE.
REQ-007 prog_addr  input  AW  program entry index to write.
REQ-008 prog_a, prog_b  input  WIDTH each  operand values to store.
REQ-009 prog_op  input  OPW  opcode to store.
REQ-010 prog_last  input  1  marks the entry as end of sequence.
REQ-011 start  input  1  begin sequence at entry 0; honoured only in IDLE.
REQ-012 loop  input  1  sampled with start; 1 = repeat sequence until abort.
REQ-013 abort  input  1  terminate run; no done pulse.
REQ-014 ready  input  1  ALU accepts current A/B/OP this cycle.
REQ-015 A, B  output  WIDTH each  registered operands to ALU.
REQ-016 OP  output  OPW  registered opcode to ALU.
REQ-017 valid  output  1  A/B/OP hold a live entry.
REQ-018 busy  output  1  high in RUN and DONE states.
REQ-019 done  output  1  one-cycle pulse at normal sequence end.
REQ-020 step  output  AW  index of entry currently presented.

Function
REQ-021 States SHALL be IDLE, RUN, DONE; encoding free.
REQ-022 IDLE: prog_we writes {prog_a, prog_b, prog_op, prog_last} to entry prog_addr at the edge; prog_we outside IDLE SHALL be ignored.
REQ-023 IDLE + start=1 at edge t: state RUN, step=0, valid=1, A/B/OP = entry 0 from cycle t+1; loop latched.
REQ-024 RUN: A/B/OP/step SHALL hold stable while valid=1 and ready=0.
REQ-025 RUN, valid&ready, entry not last: next cycle presents entry step+1.
REQ-026 Entry DEPTH-1 SHALL be treated as last regardless of its prog_last flag (no pointer overrun).
REQ-027 RUN, valid&ready, entry last, loop=0: next state DONE; valid=0, A/B/OP=0, done=1 for that one cycle; following cycle IDLE.
REQ-028 RUN, valid&ready, entry last, loop=1: next cycle presents entry 0, valid stays 1, done stays 0.
REQ-029 abort=1 in RUN or DONE SHALL force IDLE next cycle with valid=0, done=0, A/B/OP=0, step=0; abort has priority over ready.
REQ-030 start in RUN or DONE SHALL be ignored; start and prog_we together in IDLE: write occurs and start is honoured, entry 0 read reflects the new write if prog_addr=0.
REQ-031 Whenever valid=0, A, B, OP SHALL be driven 0.
REQ-032 busy = 1 exactly when state is RUN or DONE.
REQ-033 Zero-latency throughput: with ready held 1, one entry transferred per cycle.

Reset
REQ-034 reset=0 SHALL immediately (asynchronously) force IDLE, A=B=0, OP=0, valid=0, busy=0, done=0, step=0, latched loop=0.
REQ-035 reset SHALL clear all program entries to zero with last flag 0.
REQ-036 Reset asserted mid-run SHALL discard the run with no done pulse; operation resumes from IDLE after release.

Verification
REQ-037 Write entries 0:{42,21,0,0},1:{60,3,1,0},2:{0,0,0,1}; start, ready=1 -> A/B/OP = 42/21/0, 60/3/1, 0/0/0 on consecutive cycles, then done=1 one cycle, busy falls next cycle.
REQ-038 Same program, ready low 3 cycles on entry 1 -> A=60,B=3,OP=1,step=1 held 4 cycles, sequence then completes with single done.
REQ-039 Same program, loop=1 with start, ready=1 for 7 cycles -> steps 0,1,2,0,1,2,0, no done; abort -> valid=0, busy=0 next cycle, no done.
REQ-040 No last flags set, DEPTH=8 -> run ends after step 7, done pulses once.
REQ-041 reset=0 while step=1 -> outputs zero without waiting for clk; prog_we during RUN -> entry unchanged on rerun.
